mem_shift_sched: RTL

Scheduler and controller for a DEPTH-entry x WIDTH-bit shift-register delay line. It arbitrates NREQ requesters into stage 0 and advances the line under shift_en. It tracks per-stage valid/source tags and sequences the clear and drain operations. It sits in front of fixed-latency delay pipelines and returns each word tagged with its originating requester.

---
 rtl/mem_shift_sched_pkg.sv | 27 ++
 rtl/mem_shift_sched_arb.sv | 75 +++++++
 rtl/mem_shift_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_shift_sched_pkg.sv
// rtl/mem_shift_sched_pkg.sv - shared types, default sizes and helpers for mem_shift_sched
package mem_shift_sched_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int DEPTH_DEF = 8;
    localparam int NREQ_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int SRC_W_DEF = clog2_min1(NREQ_DEF);

    typedef struct packed {
        logic                 valid;
        logic [SRC_W_DEF-1:0] src;
        logic [WIDTH_DEF-1:0] data;
    } stage_t;

endpackage

// File: rtl/mem_shift_sched_arb.sv
// rtl/mem_shift_sched_arb.sv - NREQ-way one-hot arbiter, round-robin when MEM_SHIFT_SCHED_RR_EN is defined
module mem_shift_sched_arb
    import mem_shift_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = clog2_min1(NREQ);

`ifdef MEM_SHIFT_SCHED_RR_EN
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick;

    // Requesters at or above the pointer go first, otherwise wrap to the lowest one
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = req_i[i] && (i >= int'(ptr_q));
        end
        pick  = (|hi_req) ? hi_req : req_i;
        gnt_o = '0;
        win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                win      = PW'(i);
            end
        end
        if (!en_i) begin
            gnt_o = '0;
        end
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
        end
    end

    // Pointer moves past the winner only when a grant is issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_ni;

    // Fixed priority: the lowest requesting index wins
    always_comb begin
        gnt_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
        if (!en_i) begin
            gnt_o = '0;
        end
    end
`endif

endmodule

// File: rtl/mem_shift_sched.sv
// rtl/mem_shift_sched.sv - scheduled shift-register delay line with source tags (MEM_SHIFT_SCHED_RR_EN selects round-robin)
module mem_shift_sched
    import mem_shift_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREQ  = NREQ_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NREQ-1:0]             req_valid_i,
    input  logic [NREQ*WIDTH-1:0]       req_data_i,
    output logic [NREQ-1:0]             req_ready_o,
    input  logic                        shift_en_i,
    input  logic                        flush_i,
    input  logic                        drain_i,
    output logic                        out_valid_o,
    output logic [WIDTH-1:0]            out_data_o,
    output logic [clog2_min1(NREQ)-1:0] out_src_o,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy_o,
    output logic                        busy_o
);

    localparam int SW = clog2_min1(NREQ);
    localparam int OW = $clog2(DEPTH + 1);

    state_e           state_q;
    state_e           state_d;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;
    logic [DEPTH-1:0] vld_q;
    logic [SW-1:0]    src_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic             grant_en;
    logic [NREQ-1:0]  gnt;
    logic             load;
    logic             advance;
    logic             exit_w;
    logic [WIDTH-1:0] ld_data;
    logic [SW-1:0]    ld_src;

    assign advance  = shift_en_i & ~flush_i;
    assign grant_en = shift_en_i & ~flush_i & ~drain_i & (state_q != ST_DRAIN);
    assign load     = |gnt;
    assign exit_w   = advance & vld_q[DEPTH-1];

    mem_shift_sched_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .en_i   (grant_en),
        .gnt_o  (gnt)
    );

    // Select the granted requester's word and tag for stage 0
    always_comb begin
        ld_data = '0;
        ld_src  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                ld_data = req_data_i[i*WIDTH +: WIDTH];
                ld_src  = SW'(i);
            end
        end
    end

    // Occupancy tracks loads in and valid words out; flush empties it
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OW'(load) - OW'(exit_w);
        end
    end

    // Next state: flush beats drain, drain beats normal sequencing
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else if (drain_i && (state_q != ST_DRAIN)) begin
            state_d = ST_DRAIN;
        end else begin
            case (state_q)
                ST_IDLE:  if (load) state_d = ST_RUN;
                ST_RUN:   if ((occ_q == '0) && !load) state_d = ST_IDLE;
                ST_DRAIN: if (occ_q == '0) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Control state and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    // Stage array: shift on advance, bubble into stage 0 when nothing is granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                src_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else if (flush_i) begin
            vld_q <= '0;
        end else if (shift_en_i) begin
            vld_q <= {vld_q[DEPTH-2:0], load};
            for (int k = 1; k < DEPTH; k++) begin
                src_q[k]  <= src_q[k-1];
                data_q[k] <= data_q[k-1];
            end
            if (load) begin
                src_q[0]  <= ld_src;
                data_q[0] <= ld_data;
            end
        end
    end

    assign req_ready_o = gnt;
    assign out_valid_o = vld_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
    assign out_src_o   = src_q[DEPTH-1];
    assign occupancy_o = occ_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
